// File: rtl/hazard_pkg.sv
// Shared pipeline-control types: hazard FSM states and EX branch-select encodings
// (also used by the fetch stage and the EX branch unit).
package hazard_pkg;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_LSTALL = 2'd1,
    S_MWAIT  = 2'd2
  } hz_state_e;

  localparam logic [1:0] BR_IMM_RS1 = 2'd0;
  localparam logic [1:0] BR_IMM     = 2'd1;
  localparam logic [1:0] BR_PC4     = 2'd2;

  // Encoding 3 is illegal and falls through as PC+4, i.e. not taken.
  function automatic logic is_br_taken(input logic [1:0] sel);
    return (sel == BR_IMM_RS1) || (sel == BR_IMM);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the hazard unit's stall/flush performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard/flow controller: load-use stalls, taken-branch flushes and
// data-memory wait freezes, with saturating stall/flush counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1_addr,
  input  logic [4:0]       ID_rs2_addr,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic [4:0]       EX_rd_addr,
  input  logic             EX_mem_read,
  input  logic [1:0]       EX_Branch_Ctrl,
  input  logic             DM_wait,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             instr_flush_sel,
  output logic             IDEX_ctrl_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e  state, state_nxt;
  logic [1:0] bub_cnt, bub_nxt;
  logic       br_taken, lu_hit, flush_ev;

  assign br_taken = is_br_taken(EX_Branch_Ctrl);
  assign lu_hit   = EX_mem_read && (EX_rd_addr != 5'd0) &&
                    ((ID_rs1_used && (ID_rs1_addr == EX_rd_addr)) ||
                     (ID_rs2_used && (ID_rs2_addr == EX_rd_addr)));

  always_comb begin
    state_nxt       = state;
    bub_nxt         = bub_cnt;
    PC_write        = 1'b1;
    IFID_write      = 1'b1;
    instr_flush_sel = 1'b0;
    IDEX_ctrl_flush = 1'b0;
    flush_ev        = 1'b0;
    case (state)
      S_LSTALL: begin
        PC_write   = 1'b0;
        IFID_write = 1'b0;
        // A memory freeze holds the pending bubble count; no bubble is issued.
        if (!DM_wait) begin
          IDEX_ctrl_flush = 1'b1;
          if (bub_cnt <= 2'd1) begin
            state_nxt = S_RUN;
            bub_nxt   = 2'd0;
          end else begin
            bub_nxt = bub_cnt - 2'd1;
          end
        end
      end
      default: begin
        // S_RUN and S_MWAIT share rules: leaving the wait evaluates as a normal cycle.
        if (DM_wait) begin
          PC_write   = 1'b0;
          IFID_write = 1'b0;
          state_nxt  = S_MWAIT;
        end else begin
          state_nxt = S_RUN;
          if (br_taken) begin
            instr_flush_sel = 1'b1;
            IDEX_ctrl_flush = 1'b1;
            flush_ev        = 1'b1;
          end else if (lu_hit) begin
            PC_write        = 1'b0;
            IFID_write      = 1'b0;
            IDEX_ctrl_flush = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              bub_nxt   = 2'(LOAD_BUBBLES - 1);
              state_nxt = S_LSTALL;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RUN;
      bub_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_nxt;
    end
  end

  // EX holds the inserted bubble while stalling, so it cannot carry a taken branch.
  a_no_br_in_lstall: assert property (@(posedge clk) disable iff (rst)
    (state == S_LSTALL) |-> !br_taken);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!PC_write),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_ev),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: dut_a (LOAD_BUBBLES=1, CNT_W=16) and dut_b (LOAD_BUBBLES=2, CNT_W=4) on shared inputs.
module tb_hazard_ctrl_unit;

  logic       clk, rst;
  logic [4:0] ID_rs1_addr, ID_rs2_addr, EX_rd_addr;
  logic       ID_rs1_used, ID_rs2_used, EX_mem_read, DM_wait;
  logic [1:0] EX_Branch_Ctrl;

  logic        pc_a, ifid_a, fsel_a, idex_a;
  logic        pc_b, ifid_b, fsel_b, idex_b;
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;
  logic [3:0]  oa, ob;

  int total  = 0;
  int passed = 0;

  localparam logic [3:0] RUN = 4'b1100, STALL = 4'b0001, FREEZE = 4'b0000, FLUSH = 4'b1111;

  assign oa = {pc_a, ifid_a, fsel_a, idex_a};
  assign ob = {pc_b, ifid_b, fsel_b, idex_b};

  hazard_ctrl_unit #(.LOAD_BUBBLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .EX_rd_addr(EX_rd_addr), .EX_mem_read(EX_mem_read),
    .EX_Branch_Ctrl(EX_Branch_Ctrl), .DM_wait(DM_wait),
    .PC_write(pc_a), .IFID_write(ifid_a), .instr_flush_sel(fsel_a),
    .IDEX_ctrl_flush(idex_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  hazard_ctrl_unit #(.LOAD_BUBBLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .EX_rd_addr(EX_rd_addr), .EX_mem_read(EX_mem_read),
    .EX_Branch_Ctrl(EX_Branch_Ctrl), .DM_wait(DM_wait),
    .PC_write(pc_b), .IFID_write(ifid_b), .instr_flush_sel(fsel_b),
    .IDEX_ctrl_flush(idex_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are checked 1ns later.
  task automatic step(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic mr, input logic [1:0] br, input logic dw);
    @(negedge clk);
    ID_rs1_addr = rs1; ID_rs1_used = u1;
    ID_rs2_addr = rs2; ID_rs2_used = u2;
    EX_rd_addr  = rd;  EX_mem_read = mr;
    EX_Branch_Ctrl = br; DM_wait = dw;
    #1;
  endtask

  task automatic idle();
    step(5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 2'd2, 1'b0);
  endtask

  task automatic lu();
    step(5'd5, 1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 2'd2, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ID_rs1_addr = '0; ID_rs2_addr = '0; ID_rs1_used = 0; ID_rs2_used = 0;
    EX_rd_addr = '0; EX_mem_read = 0; EX_Branch_Ctrl = 2'd2; DM_wait = 0;
    #1;
    chk("reset_out_a", oa, RUN);
    chk("reset_out_b", ob, RUN);
    chk("reset_stall_a", stall_a, 0);
    chk("reset_flush_a", flush_a, 0);
    chk("reset_stall_b", stall_b, 0);
    @(negedge clk); rst = 1'b0;

    // Load-use: one stall on A, two on B
    lu();
    chk("lu_c1_a", oa, STALL);
    chk("lu_c1_b", ob, STALL);
    idle();
    chk("lu_c2_a", oa, RUN);
    chk("lu_c2_b", ob, STALL);
    chk("lu_stall_a1", stall_a, 1);
    chk("lu_stall_b1", stall_b, 1);
    idle();
    chk("lu_c3_b", ob, RUN);
    chk("lu_stall_a", stall_a, 1);
    chk("lu_stall_b", stall_b, 2);

    // No hazard via x0 or via an unused source
    step(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'd2, 1'b0);
    chk("x0_a", oa, RUN);
    chk("x0_b", ob, RUN);
    step(5'd3, 1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 2'd2, 1'b0);
    chk("unused_a", oa, RUN);
    chk("unused_b", ob, RUN);
    step(5'd3, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0, 2'd2, 1'b0);
    chk("noload_a", oa, RUN);

    // Branch wins over load-use
    step(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0);
    chk("br_lu_a", oa, FLUSH);
    chk("br_lu_b", ob, FLUSH);
    step(5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 2'd3, 1'b0);
    chk("br3_a", oa, RUN);
    chk("br_flush_a", flush_a, 1);
    chk("br_flush_b", flush_b, 1);
    chk("br_stall_a", stall_a, 1);
    step(5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    chk("br0_b", ob, FLUSH);
    idle();
    chk("br0_flush_a", flush_a, 2);
    chk("br0_flush_b", flush_b, 2);

    // DM_wait for 4 cycles while B is mid load-use stall
    lu();
    chk("mw_lu_b", ob, STALL);
    for (int i = 0; i < 4; i++) begin
      step(5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 2'd2, 1'b1);
      chk("mw_frz_a", oa, FREEZE);
      chk("mw_frz_b", ob, FREEZE);
    end
    idle();
    chk("mw_exit_a", oa, RUN);
    chk("mw_rem_bubble_b", ob, STALL);
    chk("mw_stall_a", stall_a, 6);
    chk("mw_stall_b", stall_b, 7);
    idle();
    chk("mw_done_b", ob, RUN);
    chk("mw_stall_b2", stall_b, 8);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++)
      step(5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 2'd2, 1'b1);
    chk("sat_out_b", ob, FREEZE);
    idle();
    chk("sat_stall_b", stall_b, 15);
    chk("sat_stall_a", stall_a, 26);

    // Reset in the middle of a load-use stall
    lu();
    idle();
    chk("rst_pre_b", ob, STALL);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_b", ob, RUN);
    chk("rst_mid_stall_b", stall_b, 0);
    chk("rst_mid_flush_b", flush_b, 0);
    chk("rst_mid_stall_a", stall_a, 0);
    @(negedge clk); rst = 1'b0;
    idle();
    chk("rst_no_residual_b", ob, RUN);
    chk("rst_after_stall_b", stall_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
